// File: rtl/risc_result_uart.sv
// Result-bus observer for the miniRISC core: captures each new {out1,out2} pair
// into a small FIFO and serialises it as a 9-byte 8N1 UART frame (A5 + 8 data bytes).
module risc_result_uart #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] out1,
  input  logic [31:0] out2,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;
  localparam logic [3:0]       LAST_BYTE = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic [63:0]      pair;
  logic [63:0]      last_q, last_d;
  logic [63:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             change, push, pop;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [3:0]       byte_q, byte_d;
  logic [63:0]      frame_q, frame_d;
  logic [7:0]       cur_byte;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;

  assign pair   = {out1, out2};
  assign change = en && (pair != last_q);

  // A pop in the same cycle frees a slot, so a push on a full FIFO still fits.
  always_comb begin
    push     = change && ((count_q != FIFO_FULL) || pop);
    last_d   = change ? pair : last_q;
    ovf_d    = ovf_q || (change && !push);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= pair;
    end
  end

  // Byte 0 is the sync byte; later bytes come from the top of the frame register.
  assign cur_byte = (byte_q == 4'd0) ? SYNC_BYTE : frame_q[63:56];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    frame_d = frame_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          frame_d = fifo_mem[rd_ptr_q];
          byte_d  = 4'd0;
          cnt_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = DATA;
          tx_d    = cur_byte[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (byte_q < LAST_BYTE) begin
            if (byte_q != 4'd0) begin
              frame_d = {frame_q[55:0], 8'h00};
            end
            byte_d  = byte_q + 4'd1;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_risc_result_uart.sv
// Directed bench for risc_result_uart: frame contents, bit timing, FIFO overflow,
// enable gating and asynchronous reset, on a 16- and a 4-clock-per-bit instance.
module tb_risc_result_uart;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, en4;
  logic [31:0] o1, o2, a4, b4;
  logic        tx, busy, ovf;
  logic        tx4, busy4, ovf4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  risc_result_uart #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .out1(o1), .out2(o2),
    .tx(tx), .busy(busy), .overflow(ovf)
  );

  risc_result_uart #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .out1(a4), .out2(b4),
    .tx(tx4), .busy(busy4), .overflow(ovf4)
  );

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic line(input bit sel);
    return sel ? tx4 : tx;
  endfunction

  // Waits (bounded) for a start bit, then compares every cycle of the frame
  // against the ideal 8N1 waveform and decodes the bytes at mid-bit.
  task automatic rx_frame(input bit sel, input int cpb, input logic [63:0] pr,
                          input int max_wait, output int lat, output int bad,
                          output logic [71:0] got);
    logic [71:0] exp;
    int j, pos, off;
    logic eb;
    exp = {8'hA5, pr};
    lat = 0;
    bad = 0;
    got = '0;
    @(negedge clk);
    while (line(sel) !== 1'b0) begin
      if (lat >= max_wait) begin
        lat = -1;
        bad = 90 * cpb;
        return;
      end
      lat++;
      @(negedge clk);
    end
    for (int k = 0; k < 90 * cpb; k++) begin
      if (k > 0) @(negedge clk);
      j   = k / (10 * cpb);
      pos = (k % (10 * cpb)) / cpb;
      off = k % cpb;
      if (pos == 0) eb = 1'b0;
      else if (pos == 9) eb = 1'b1;
      else eb = exp[64 - 8 * j + (pos - 1)];
      if (line(sel) !== eb) bad++;
      if (pos >= 1 && pos <= 8 && off == cpb / 2) got[64 - 8 * j + (pos - 1)] = line(sel);
    end
  endtask

  task automatic frame_checks(input string tag, input bit sel, input int cpb,
                              input logic [63:0] pr, input int exp_lat);
    int lat, bad;
    logic [71:0] got;
    rx_frame(sel, cpb, pr, 3000, lat, bad, got);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_bits"}, bad, 0);
    check({tag, "_bytes"}, got, {8'hA5, pr});
  endtask

  logic [63:0] pr [6];

  initial begin
    int bad_tx, bad_busy, lat, bad, w;
    logic [71:0] got;

    pr[0] = 64'h11111111_22222222;
    pr[1] = 64'h33333333_44444444;
    pr[2] = 64'h55555555_66666666;
    pr[3] = 64'h77777777_88888888;
    pr[4] = 64'h99999999_AAAAAAAA;
    pr[5] = 64'hBBBBBBBB_CCCCCCCC;

    rst = 1'b1;
    en  = 1'b0;  o1 = '0; o2 = '0;
    en4 = 1'b0;  a4 = '0; b4 = '0;
    #3 rst = 1'b0;
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_tx4", tx4, 1);

    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    en = 1'b1;
    bad_tx = 0;
    bad_busy = 0;
    repeat (2000) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    check("idle_tx_cycles", bad_tx, 0);
    check("idle_busy_cycles", bad_busy, 0);

    // Single frame
    @(posedge clk); #1;
    o1 = 32'h12345678;
    o2 = 32'h9ABCDEF0;
    frame_checks("f1", 1'b0, 16, {o1, o2}, 2);
    check("f1_busy_last_stop", busy, 1);
    @(negedge clk);
    check("f1_busy_after", busy, 0);
    check("f1_tx_after", tx, 1);

    // Six pairs on consecutive cycles into a depth-4 FIFO
    @(posedge clk); #1;
    o1 = pr[0][63:32];
    o2 = pr[0][31:0];
    fork
      begin
        for (int i = 1; i < 6; i++) begin
          @(posedge clk); #1;
          o1 = pr[i][63:32];
          o2 = pr[i][31:0];
        end
        check("ovf_before_drop", ovf, 0);
        @(posedge clk); #1;
        check("ovf_after_drop", ovf, 1);
      end
      begin
        frame_checks("q0", 1'b0, 16, pr[0], 2);
        for (int i = 1; i < 5; i++) frame_checks($sformatf("q%0d", i), 1'b0, 16, pr[i], 1);
        rx_frame(1'b0, 16, pr[5], 2000, lat, bad, got);
        check("no_sixth_frame", lat, -1);
      end
    join
    @(negedge clk);
    check("ovf_sticky", ovf, 1);
    check("q_busy_after", busy, 0);

    // Enable gating
    @(posedge clk); #1;
    en = 1'b0;
    o1 = 32'hDEADBEEF;
    o2 = 32'h00000001;
    rx_frame(1'b0, 16, {o1, o2}, 50, lat, bad, got);
    check("en0_no_frame", lat, -1);
    @(posedge clk); #1;
    en = 1'b1;
    frame_checks("en1", 1'b0, 16, 64'hDEADBEEF_00000001, 2);

    // Four clocks per bit
    @(posedge clk); #1;
    en4 = 1'b1;
    a4 = 32'h0F1E2D3C;
    b4 = 32'h4B5A6978;
    frame_checks("c4", 1'b1, 4, {a4, b4}, 2);
    check("c4_busy_last_stop", busy4, 1);
    @(negedge clk);
    check("c4_busy_after", busy4, 0);
    check("c4_tx_after", tx4, 1);

    // Asynchronous reset during byte 3
    @(posedge clk); #1;
    o1 = 32'hCAFEF00D;
    o2 = 32'h13579BDF;
    w = 0;
    @(negedge clk);
    while (tx !== 1'b0 && w < 100) begin
      w++;
      @(negedge clk);
    end
    check("r_start_latency", w, 2);
    repeat (3 * 160 + 50) @(negedge clk);
    check("r_busy_mid_frame", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("r_tx_async", tx, 1);
    check("r_busy_async", busy, 0);
    check("r_ovf_async", ovf, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    frame_checks("r_fresh", 1'b0, 16, 64'hCAFEF00D_13579BDF, 1);
    @(negedge clk);
    check("r_ovf_after", ovf, 0);
    check("r_busy_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/risc_result_uart.md
# risc_result_uart

Downstream observer for the miniRISC core: watches the core's two 32-bit result buses `out1`/`out2`, captures every new pair into a small FIFO, and serialises each captured pair as a 9-byte UART 8N1 frame on a single `tx` line. It is the first block after the core's output ports and lets the processor's results be checked on a board pin or logged by a bench UART receiver without halting the core.

## Interface
- `CLKS_PER_BIT`, 16, clock cycles per UART bit; legal range ≥ 2.
- `FIFO_DEPTH`, 4, number of captured pairs buffered; power of 2, ≥ 2.

- `clk`  input  1  system clock; all state changes on rising edge.
- `rst`  input  1  asynchronous, active-low reset: 0 resets immediately, 1 runs.
- `en`  input  1  capture enable; 0 = ignore bus changes.
- `out1`  input  32  core result bus 1.
- `out2`  input  32  core result bus 2.
- `tx`  output  1  UART serial out; idles high.
- `busy`  output  1  1 while a frame is on the line or the FIFO is non-empty.
- `overflow`  output  1  sticky; set when a capture is dropped on full FIFO.

## Operation
- Reset values: `tx`=1, `busy`=0, `overflow`=0, FIFO empty, last-captured pair register = {0,0}, FSM in IDLE, all counters 0.
- Change detect: in a cycle with `en`=1 and {`out1`,`out2`} ≠ last-captured pair:
  - the pair is pushed at that cycle's rising edge;
  - the last-captured register updates to the new pair.
- With `en`=0: no compare, no push, and the last-captured register holds its value.
- FIFO full on a detected change: the pair is dropped and `overflow` is set. `overflow` stays 1 until reset. The last-captured register still updates, so a steady value is not re-detected.
- Simultaneous push and pop when full: the pop frees the slot, so the push is accepted and `overflow` is not set.
- Frame format: byte 0 = 0xA5 sync, bytes 1–4 = `out1` MSB byte first, bytes 5–8 = `out2` MSB byte first.
- Byte format: 8N1. One start bit (0), 8 data bits LSB first, one stop bit (1). Each bit lasts `CLKS_PER_BIT` cycles.
- FSM states and transitions:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into a 64-bit shift/frame register, set byte index to 0, and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx` = current byte[bit index] for `CLKS_PER_BIT` cycles per bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. Then, if byte index < 8, increment it and go to START (no idle gap between bytes); otherwise go to IDLE.
- `busy` = (state ≠ IDLE) OR (FIFO count ≠ 0). It is registered consistently with the state and count, with no extra delay.
- Reset asserted mid-frame: `tx` goes to 1 and `busy` to 0 immediately, without waiting for a clock. The partial frame is abandoned, the FIFO is flushed and `overflow` is cleared.

## Timing
- Capture latency: a change present in cycle N is in the FIFO after the edge ending cycle N.
- Pop: FSM is in IDLE in cycle N+1 and pops there. The start bit is driven from cycle N+2.
- Frame duration: 9 × 10 × `CLKS_PER_BIT` cycles; 1440 cycles at the default.
- Gap between back-to-back frames: exactly 1 IDLE cycle with `tx`=1.
- Throughput: the sustained capture rate must stay below one pair per frame time; otherwise captures are dropped with `overflow` set.
- `tx` is driven directly from a flop, so it is glitch-free.

## Test plan
- Reset, `en`=1, `out1`=`out2`=0 held → no push, `tx`=1, `busy`=0 for 2000 cycles.
- `out1`=0x12345678, `out2`=0x9ABCDEF0 applied at cycle N and held → start bit at cycle N+2, bytes decoded A5 12 34 56 78 9A BC DE F0, `tx` back at 1 by N+2+1440, `busy` then falls.
- Six distinct pairs on six consecutive cycles, `FIFO_DEPTH`=4 → exactly the first five frames transmitted in order, sixth dropped, `overflow`=1 from the sixth cycle on.
- `en`=0 while the bus changes to 0xDEADBEEF/0x1, then `en`=1 with the bus unchanged → one frame for 0xDEADBEEF/0x00000001 starting 2 cycles after `en` rises; no frame while `en`=0.
- `CLKS_PER_BIT`=4 → each bit measured exactly 4 cycles, each byte 40 cycles, frame 360 cycles.
- `rst` pulled low during byte 3 → `tx`=1 and `busy`=0 without a clock edge. After release with the bus holding a non-zero pair → a fresh full frame for that pair, and `overflow`=0.
